// File: rtl/otter_intr_fsm.sv
// OTTER multicycle control FSM with edge-triggered, MIE-gated interrupt entry.
// Strobes are decoded from the current state and opcode; only INT_PEND is registered.
module otter_intr_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] IR_OPCODE,
  input  logic [2:0] IR_FUNCT,
  input  logic       INTR,
  input  logic       MIE,
  output logic       PC_WRITE,
  output logic       REG_WRITE,
  output logic       MEM_WE2,
  output logic       MEM_RDEN1,
  output logic       MEM_RDEN2,
  output logic       PC_RST,
  output logic       CSR_WE,
  output logic       MRET_EXEC,
  output logic       INT_TAKEN,
  output logic       INT_PEND
);

  // state    | meaning
  // ST_INIT  | PC held in reset for one cycle
  // ST_FETCH | instruction memory read
  // ST_EXEC  | execute; LOAD issues the data read and continues to ST_WB
  // ST_WB    | LOAD write-back
  // ST_INTR  | interrupt entry: jump to MTVEC, save MEPC
  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_INTR
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t r_state;
  logic   r_intr_d;
  logic   r_int_pend;

  logic w_is_load;
  logic w_take_intr;
  logic w_intr_edge;

  assign w_is_load   = (IR_OPCODE == OP_LOAD);
  assign w_take_intr = r_int_pend & MIE;
  assign w_intr_edge = INTR & ~r_intr_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_INIT;
      r_intr_d   <= 1'b0;
      r_int_pend <= 1'b0;
    end else begin
      r_intr_d <= INTR;
      // Clearing on interrupt entry takes priority, so an edge landing in ST_INTR is dropped.
      if (r_state == ST_INTR)
        r_int_pend <= 1'b0;
      else if (w_intr_edge)
        r_int_pend <= 1'b1;

      case (r_state)
        ST_INIT:  r_state <= ST_FETCH;
        ST_FETCH: r_state <= ST_EXEC;
        ST_EXEC: begin
          if (w_is_load)        r_state <= ST_WB;
          else if (w_take_intr) r_state <= ST_INTR;
          else                  r_state <= ST_FETCH;
        end
        ST_WB:    r_state <= w_take_intr ? ST_INTR : ST_FETCH;
        ST_INTR:  r_state <= ST_FETCH;
        default:  r_state <= ST_INIT;
      endcase
    end
  end

  always_comb begin
    PC_WRITE  = 1'b0;
    REG_WRITE = 1'b0;
    MEM_WE2   = 1'b0;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    PC_RST    = 1'b0;
    CSR_WE    = 1'b0;
    MRET_EXEC = 1'b0;
    INT_TAKEN = 1'b0;
    case (r_state)
      ST_INIT:  PC_RST    = 1'b1;
      ST_FETCH: MEM_RDEN1 = 1'b1;
      ST_EXEC: begin
        case (IR_OPCODE)
          OP_LOAD:   MEM_RDEN2 = 1'b1;
          OP_STORE: begin
            MEM_WE2  = 1'b1;
            PC_WRITE = 1'b1;
          end
          OP_BRANCH: PC_WRITE = 1'b1;
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_OPIMM: begin
            PC_WRITE  = 1'b1;
            REG_WRITE = 1'b1;
          end
          OP_SYSTEM: begin
            PC_WRITE = 1'b1;
            if (IR_FUNCT == 3'b000) begin
              MRET_EXEC = 1'b1;
            end else begin
              REG_WRITE = 1'b1;
              CSR_WE    = 1'b1;
            end
          end
          // Unknown opcodes retire as a NOP rather than stalling.
          default:   PC_WRITE = 1'b1;
        endcase
      end
      ST_WB: begin
        REG_WRITE = 1'b1;
        PC_WRITE  = 1'b1;
      end
      ST_INTR: begin
        PC_WRITE  = 1'b1;
        INT_TAKEN = 1'b1;
      end
      default: ;
    endcase
  end

  assign INT_PEND = r_int_pend;

endmodule

// File: tb/tb_otter_intr_fsm.sv
// Self-checking bench for otter_intr_fsm: directed decode table, interrupt/reset
// corner sequences, then randomized instructions against an instruction-level model.
module tb_otter_intr_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [6:0] IR_OPCODE = '0;
  logic [2:0] IR_FUNCT = '0;
  logic       INTR = 1'b0;
  logic       MIE = 1'b0;
  logic PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2;
  logic PC_RST, CSR_WE, MRET_EXEC, INT_TAKEN, INT_PEND;

  int n_tests = 0;
  int n_fail  = 0;

  otter_intr_fsm dut (
    .CLK(CLK), .RST(RST), .IR_OPCODE(IR_OPCODE), .IR_FUNCT(IR_FUNCT),
    .INTR(INTR), .MIE(MIE), .PC_WRITE(PC_WRITE), .REG_WRITE(REG_WRITE),
    .MEM_WE2(MEM_WE2), .MEM_RDEN1(MEM_RDEN1), .MEM_RDEN2(MEM_RDEN2),
    .PC_RST(PC_RST), .CSR_WE(CSR_WE), .MRET_EXEC(MRET_EXEC),
    .INT_TAKEN(INT_TAKEN), .INT_PEND(INT_PEND)
  );

  always #5 CLK = ~CLK;

  // Output word: {PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2, PC_RST, CSR_WE, MRET_EXEC, INT_TAKEN, INT_PEND}
  localparam logic [9:0] PCW   = 10'b1000000000;
  localparam logic [9:0] RW    = 10'b0100000000;
  localparam logic [9:0] WE2   = 10'b0010000000;
  localparam logic [9:0] RD1   = 10'b0001000000;
  localparam logic [9:0] RD2   = 10'b0000100000;
  localparam logic [9:0] PCR   = 10'b0000010000;
  localparam logic [9:0] CSR   = 10'b0000001000;
  localparam logic [9:0] MRET  = 10'b0000000100;
  localparam logic [9:0] TAKEN = 10'b0000000010;
  localparam logic [9:0] PEND  = 10'b0000000001;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, BRANCH = 7'b1100011;
  localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, ADD = 7'b0110011, OPIMM = 7'b0010011;
  localparam logic [6:0] SYS = 7'b1110011, UNDEF = 7'b1111111;

  logic [9:0] w_out;
  assign w_out = {PC_WRITE, REG_WRITE, MEM_WE2, MEM_RDEN1, MEM_RDEN2,
                  PC_RST, CSR_WE, MRET_EXEC, INT_TAKEN, INT_PEND};

  typedef struct {
    logic [6:0] op;
    logic [2:0] funct;
    logic [9:0] exp_exec;
    string      name;
  } vec_t;

  vec_t vecs[$];

  // Model state: pending flag and last sampled INTR level.
  logic m_pend;
  logic m_prev;

  task automatic drive(input logic rst, input logic [6:0] op, input logic [2:0] f,
                       input logic intr, input logic mie);
    RST = rst; IR_OPCODE = op; IR_FUNCT = f; INTR = intr; MIE = mie;
  endtask

  task automatic chk(input string name, input logic [9:0] exp);
    @(negedge CLK);
    n_tests++;
    if (w_out !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, w_out, exp, $time);
    end
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [9:0] exec_word(input logic [6:0] op, input logic [2:0] f);
    case (op)
      LOAD:   return RD2;
      STORE:  return PCW | WE2;
      BRANCH: return PCW;
      LUI, AUIPC, JAL, JALR, ADD, OPIMM: return PCW | RW;
      SYS:    return (f == 3'b000) ? (PCW | MRET) : (PCW | RW | CSR);
      default: return PCW;
    endcase
  endfunction

  task automatic model_clock(input logic intr, input logic entry);
    if (entry) m_pend = 1'b0;
    else if (intr && !m_prev) m_pend = 1'b1;
    m_prev = intr;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops[12];
    ops = '{LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR, ADD, OPIMM, SYS, UNDEF, 7'b0001111};

    vecs.push_back('{LOAD,   3'b010, RD2,              "exec_load"});
    vecs.push_back('{STORE,  3'b010, PCW | WE2,        "exec_store"});
    vecs.push_back('{BRANCH, 3'b000, PCW,              "exec_branch"});
    vecs.push_back('{LUI,    3'b000, PCW | RW,         "exec_lui"});
    vecs.push_back('{AUIPC,  3'b000, PCW | RW,         "exec_auipc"});
    vecs.push_back('{JAL,    3'b000, PCW | RW,         "exec_jal"});
    vecs.push_back('{JALR,   3'b000, PCW | RW,         "exec_jalr"});
    vecs.push_back('{ADD,    3'b000, PCW | RW,         "exec_op"});
    vecs.push_back('{OPIMM,  3'b000, PCW | RW,         "exec_opimm"});
    vecs.push_back('{SYS,    3'b001, PCW | RW | CSR,   "exec_csrrw"});
    vecs.push_back('{SYS,    3'b110, PCW | RW | CSR,   "exec_csrrsi"});
    vecs.push_back('{SYS,    3'b000, PCW | MRET,       "exec_mret"});
    vecs.push_back('{UNDEF,  3'b000, PCW,              "exec_undef"});

    // Reset held, then release sequence
    drive(1, ADD, 0, 0, 1);
    @(posedge CLK); #1;
    chk("rst_hold0", PCR);
    chk("rst_hold1", PCR);
    drive(0, ADD, 0, 0, 1);
    chk("rel_c0_init", PCR);
    chk("rel_c1_fetch", RD1);
    chk("rel_c2_exec", PCW | RW);

    // Decode table; each instruction starts in FETCH
    foreach (vecs[i]) begin
      drive(0, vecs[i].op, vecs[i].funct, 0, 1);
      chk({vecs[i].name, "_fetch"}, RD1);
      chk(vecs[i].name, vecs[i].exp_exec);
      if (vecs[i].op == LOAD) chk("load_wb", PCW | RW);
    end

    // One-cycle INTR pulse during FETCH of an ADD
    drive(0, ADD, 0, 1, 1);
    chk("pulse_fetch", RD1);
    drive(0, ADD, 0, 0, 1);
    chk("pulse_exec_pend", PCW | RW | PEND);
    chk("pulse_intr_state", PCW | TAKEN | PEND);
    chk("pulse_fetch_after", RD1);
    chk("pulse_exec_after", PCW | RW);

    // Edge arriving during the INTR state is lost
    drive(0, ADD, 0, 1, 1);
    chk("lost_fetch", RD1);
    drive(0, ADD, 0, 0, 1);
    chk("lost_exec", PCW | RW | PEND);
    drive(0, ADD, 0, 1, 1);
    chk("lost_intr_state", PCW | TAKEN | PEND);
    drive(0, ADD, 0, 0, 1);
    chk("lost_fetch_after", RD1);
    chk("lost_exec_after", PCW | RW);

    // MIE=0 with INTR high for 20 cycles, then MIE=1
    for (int i = 0; i < 10; i++) begin
      drive(0, ADD, 0, 1, 0);
      chk("mie0_fetch", (i == 0) ? RD1 : (RD1 | PEND));
      chk("mie0_exec", PCW | RW | PEND);
    end
    drive(0, ADD, 0, 1, 1);
    chk("mie1_fetch", RD1 | PEND);
    chk("mie1_exec", PCW | RW | PEND);
    chk("mie1_intr_state", PCW | TAKEN | PEND);
    for (int i = 0; i < 3; i++) begin
      chk("held_fetch", RD1);
      chk("held_exec", PCW | RW);
    end

    // Edge during LOAD's EXEC: LOAD completes before entry
    drive(0, LOAD, 2, 0, 1);
    chk("ld_intr_fetch", RD1);
    drive(0, LOAD, 2, 1, 1);
    chk("ld_intr_exec", RD2);
    drive(0, LOAD, 2, 0, 1);
    chk("ld_intr_wb", PCW | RW | PEND);
    chk("ld_intr_state", PCW | TAKEN | PEND);
    drive(0, ADD, 0, 0, 1);
    chk("ld_intr_fetch_after", RD1);
    chk("ld_intr_exec_after", PCW | RW);

    // Reset during a STORE's EXEC
    drive(0, STORE, 2, 0, 1);
    chk("st_rst_fetch", RD1);
    drive(1, STORE, 2, 0, 1);
    chk("st_rst_exec", PCW | WE2);
    chk("st_rst_held", PCR);
    drive(0, ADD, 0, 0, 1);
    chk("st_rst_init", PCR);
    chk("st_rst_fetch2", RD1);
    chk("st_rst_exec2", PCW | RW);

    // Reset during INTR state clears pending
    drive(0, ADD, 0, 1, 1);
    chk("ir_rst_fetch", RD1);
    drive(0, ADD, 0, 0, 1);
    chk("ir_rst_exec", PCW | RW | PEND);
    drive(1, ADD, 0, 0, 1);
    chk("ir_rst_intr", PCW | TAKEN | PEND);
    chk("ir_rst_held", PCR);
    drive(0, ADD, 0, 0, 1);
    chk("ir_rst_init", PCR);

    // Randomized instructions against the instruction-level model
    m_pend = 1'b0;
    m_prev = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [6:0] op;
      logic [2:0] f;
      int ncyc;
      logic take;
      logic intr, mie;
      logic [9:0] exp;
      op = ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      f = 3'($urandom_range(0, 7));
      ncyc = (op == LOAD) ? 3 : 2;
      take = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
        intr = ($urandom_range(0, 3) == 0);
        mie  = ($urandom_range(0, 3) != 0);
        drive(0, op, f, intr, mie);
        exp = (c == 0) ? RD1 : (c == 1) ? exec_word(op, f) : (PCW | RW);
        exp = exp | {9'b0, m_pend};
        chk("rand_instr", exp);
        if (c == ncyc - 1) take = m_pend && mie;
        model_clock(intr, 1'b0);
      end
      if (take) begin
        intr = ($urandom_range(0, 3) == 0);
        mie  = 1'($urandom_range(0, 1));
        drive(0, op, f, intr, mie);
        chk("rand_entry", PCW | TAKEN | {9'b0, m_pend});
        model_clock(intr, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/otter_intr_fsm.md
OTTER_INTR_FSM -- requirements
Module: otter_intr_fsm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named CLK and RST.
REQ-002 The ports SHALL be as follows:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous active-high reset.
- IR_OPCODE  in  7  current instruction bits [6:0].
- IR_FUNCT  in  3  current instruction bits [14:12].
- INTR  in  1  external interrupt request, level input, already synchronous to CLK.
- MIE  in  1  machine interrupt enable from the CSR file.
- PC_WRITE  out  1  PC register load enable.
- REG_WRITE  out  1  register-file write enable.
- MEM_WE2  out  1  data-port write enable.
- MEM_RDEN1  out  1  instruction-port read enable.
- MEM_RDEN2  out  1  data-port read enable.
- PC_RST  out  1  PC reset.
- CSR_WE  out  1  CSR write enable.
- MRET_EXEC  out  1  MRET executing; the decoder selects MEPC.
- INT_TAKEN  out  1  interrupt entry; the decoder selects MTVEC and the CSR file saves MEPC.
- INT_PEND  out  1  registered pending-interrupt flag.
REQ-003 All outputs except INT_PEND SHALL be combinational decodes of the current state and inputs (Moore/Mealy mix). INT_PEND SHALL be a register output.

Function
REQ-004 The FSM SHALL have five states, one per line:
- INIT
- FETCH
- EXEC
- WB
- INTR
REQ-005 INIT SHALL assert PC_RST=1 with all other strobes 0, and SHALL go to FETCH after exactly one cycle.
REQ-006 FETCH SHALL assert MEM_RDEN1=1 only, and SHALL always go to EXEC on the next cycle.
REQ-007 EXEC strobes SHALL depend on IR_OPCODE as follows:
- LOAD (0000011): MEM_RDEN2=1 only; next state WB.
- STORE (0100011): MEM_WE2=1 and PC_WRITE=1.
- BRANCH (1100011): PC_WRITE=1.
- LUI (0110111), AUIPC (0010111), JAL (1101111), JALR (1100111), OP (0110011), OP-IMM (0010011): PC_WRITE=1 and REG_WRITE=1.
- SYSTEM (1110011) with IR_FUNCT!=000: PC_WRITE=1, REG_WRITE=1, CSR_WE=1.
- SYSTEM with IR_FUNCT=000 (MRET): PC_WRITE=1 and MRET_EXEC=1.
- Any other opcode: PC_WRITE=1 only; executes as a NOP and does not stall.
REQ-008 WB SHALL assert REG_WRITE=1 and PC_WRITE=1.
REQ-009 Leaving EXEC (all opcodes except LOAD) or leaving WB, the next state SHALL be INTR if INT_PEND=1 and MIE=1, and FETCH otherwise.
REQ-010 INTR SHALL assert PC_WRITE=1 and INT_TAKEN=1 for exactly one cycle, then go to FETCH.
REQ-011 INTR edge detection SHALL work as follows:
- A registered copy of INTR is kept.
- INT_PEND is set on the cycle after an INTR 0->1 edge is sampled.
- A level held high SHALL NOT re-set INT_PEND after it has been cleared.
REQ-012 INT_PEND SHALL clear on the clock edge that ends the INTR state.
REQ-013 If a new INTR rising edge is sampled in the same cycle as the INTR state, clear SHALL win and that edge SHALL be lost.
REQ-014 While MIE=0, INT_PEND SHALL hold its value. The interrupt SHALL be taken at the first EXEC/WB exit after MIE returns to 1.
REQ-015 Interrupts SHALL never be taken from INIT or FETCH, and SHALL never preempt a LOAD between EXEC and WB.
REQ-016 No two of MEM_WE2, MEM_RDEN1 and MEM_RDEN2 SHALL be asserted in the same cycle.
REQ-017 PC_WRITE SHALL be asserted exactly once per retired instruction and once per interrupt entry.

Reset
REQ-018 RST=1 at any clock edge, including mid-instruction or during INTR, SHALL force state INIT, clear INT_PEND, and clear the registered INTR copy.
REQ-019 While RST=1 is applied, from the cycle after the first RST edge all outputs SHALL be 0 except PC_RST=1.
REQ-020 RST asserted during EXEC of a STORE SHALL deassert MEM_WE2 from the following cycle; no further write SHALL occur.

Verification
REQ-021 Reset release: the bench SHALL release RST and check the following sequence, one per line:
- Cycle 0: INIT, PC_RST=1.
- Cycle 1: FETCH, MEM_RDEN1=1.
- Cycle 2: EXEC.
REQ-022 OP-IMM 0010011: FETCH -> EXEC with PC_WRITE=REG_WRITE=1, then FETCH. A LOAD SHALL take 3 cycles, asserting MEM_RDEN2 in EXEC and REG_WRITE in WB.
REQ-023 With MIE=1 and an INTR pulse of 1 cycle during FETCH of an ADD, the bench SHALL check the following sequence, one per line:
- INT_PEND=1 in EXEC.
- INTR state next, with INT_TAKEN=1 and PC_WRITE=1.
- FETCH.
- INT_PEND=0.
REQ-024 With MIE=0 and INTR held high for 20 cycles, INT_PEND SHALL remain 1 and INT_TAKEN SHALL stay 0. After MIE goes 1, exactly one INT_TAKEN SHALL occur, with no retrigger while INTR stays high.
REQ-025 INTR edge during a LOAD's EXEC SHALL be checked as follows:
- The transition SHALL be EXEC -> WB -> INTR.
- The LOAD SHALL not be interrupted.
REQ-026 SYSTEM opcode checks: with funct 001, CSR_WE=1 in EXEC; with funct 000, MRET_EXEC=1 and REG_WRITE=0. An undefined opcode 1111111 SHALL give PC_WRITE=1 only.
